// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the processor's single 16-bit memory port between
// the CPU and one DMA requester. DMA is granted the port in bounded bursts.
// The CPU is stalled while DMA owns the port. After a burst ends on its length
// limit, the CPU is guaranteed a minimum number of memory cycles.
module mem_port_arbiter #(
    parameter int MAXBURST = 4,  // 1..15 consecutive DMA cycles per burst
    parameter int CPU_MIN  = 1   // 1..15 CPU cycles after a forced burst end
) (
    input  logic        clk,
    input  logic        rst,
    // CPU side
    input  logic [15:0] c_a,
    input  logic [15:0] c_wd,
    input  logic        c_wen,
    output logic [15:0] c_rd,
    output logic        c_stall,
    // DMA side
    input  logic        d_req,
    input  logic [15:0] d_a,
    input  logic [15:0] d_wd,
    input  logic        d_wen,
    output logic        d_gnt,
    output logic [15:0] d_rd,
    output logic [15:0] xfer_count,
    // Memory side
    output logic [15:0] Ma,
    output logic [15:0] Mwd,
    output logic        Mwen,
    input  logic [15:0] Mrd
);

    typedef enum logic [0:0] {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } owner_t;

    localparam logic [3:0] BURST_LAST = 4'(MAXBURST - 1);
    localparam logic [3:0] HOLD_INIT  = 4'(CPU_MIN - 1);

    owner_t      owner_q, owner_d;
    logic [3:0]  bcnt_q,  bcnt_d;
    logic [3:0]  hcnt_q,  hcnt_d;
    logic [15:0] xfer_q,  xfer_d;
    logic        gnt_s;

    // Next-state logic for port ownership, burst length, CPU hold-off and transfer count
    always_comb begin
        owner_d = owner_q;
        bcnt_d  = bcnt_q;
        hcnt_d  = hcnt_q;
        xfer_d  = xfer_q;
        case (owner_q)
            CPU_OWN: begin
                if (hcnt_q != 4'd0) begin
                    // CPU hold-off window: DMA requests are ignored
                    hcnt_d = hcnt_q - 4'd1;
                end else if (d_req) begin
                    owner_d = DMA_OWN;
                    bcnt_d  = 4'd0;
                end else begin
                    owner_d = CPU_OWN;
                end
            end
            DMA_OWN: begin
                if (!d_req) begin
                    // Dropped request: no transfer, CPU gets the next cycle
                    owner_d = CPU_OWN;
                    hcnt_d  = 4'd0;
                end else if (bcnt_q >= BURST_LAST) begin
                    // Last cycle of a full burst still transfers
                    xfer_d  = xfer_q + 16'd1;
                    owner_d = CPU_OWN;
                    hcnt_d  = HOLD_INIT;
                end else begin
                    xfer_d = xfer_q + 16'd1;
                    bcnt_d = bcnt_q + 4'd1;
                end
            end
            default: begin
                owner_d = CPU_OWN;
                bcnt_d  = 4'd0;
                hcnt_d  = 4'd0;
            end
        endcase
    end

    // State registers with synchronous reset returning the port to the CPU
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= CPU_OWN;
            bcnt_q  <= 4'd0;
            hcnt_q  <= 4'd0;
            xfer_q  <= 16'd0;
        end else begin
            owner_q <= owner_d;
            bcnt_q  <= bcnt_d;
            hcnt_q  <= hcnt_d;
            xfer_q  <= xfer_d;
        end
    end

    // Port steering from the registered owner; writes are blocked during reset
    always_comb begin
        gnt_s   = (owner_q == DMA_OWN);
        d_gnt   = gnt_s;
        c_stall = gnt_s;
        c_rd    = Mrd;
        d_rd    = Mrd;
        if (gnt_s) begin
            Ma  = d_a;
            Mwd = d_wd;
        end else begin
            Ma  = c_a;
            Mwd = c_wd;
        end
        if (rst) begin
            Mwen = 1'b0;
        end else if (gnt_s) begin
            Mwen = d_wen & d_req;
        end else begin
            Mwen = c_wen;
        end
    end

    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance (MAXBURST=4, CPU_MIN=2)
// for the functional sequence, one (MAXBURST=15, CPU_MIN=1) for counter wrap.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic        rst, c_wen, d_req, d_wen;
    logic [15:0] c_a, c_wd, d_a, d_wd, Mrd;
    logic [15:0] c_rd, d_rd, xfer_count, Ma, Mwd;
    logic        c_stall, d_gnt, Mwen;

    // wrap instance signals
    logic        rst_w;
    logic        d_req_w = 1'b1;
    logic        c_wen_w = 1'b0;
    logic        d_wen_w = 1'b0;
    logic [15:0] c_a_w = 16'h0001, c_wd_w = 16'h0002;
    logic [15:0] d_a_w = 16'h0F0F, d_wd_w = 16'h0003, Mrd_w = 16'h0004;
    logic [15:0] c_rd_w, d_rd_w, xfer_w, Ma_w, Mwd_w;
    logic        c_stall_w, d_gnt_w, Mwen_w;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_x;
    logic        exp_g;

    mem_port_arbiter #(.MAXBURST(4), .CPU_MIN(2)) u_dut (
        .clk(clk), .rst(rst),
        .c_a(c_a), .c_wd(c_wd), .c_wen(c_wen), .c_rd(c_rd), .c_stall(c_stall),
        .d_req(d_req), .d_a(d_a), .d_wd(d_wd), .d_wen(d_wen), .d_gnt(d_gnt),
        .d_rd(d_rd), .xfer_count(xfer_count),
        .Ma(Ma), .Mwd(Mwd), .Mwen(Mwen), .Mrd(Mrd)
    );

    mem_port_arbiter #(.MAXBURST(15), .CPU_MIN(1)) u_wrap (
        .clk(clk), .rst(rst_w),
        .c_a(c_a_w), .c_wd(c_wd_w), .c_wen(c_wen_w), .c_rd(c_rd_w), .c_stall(c_stall_w),
        .d_req(d_req_w), .d_a(d_a_w), .d_wd(d_wd_w), .d_wen(d_wen_w), .d_gnt(d_gnt_w),
        .d_rd(d_rd_w), .xfer_count(xfer_w),
        .Ma(Ma_w), .Mwd(Mwd_w), .Mwen(Mwen_w), .Mrd(Mrd_w)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle before sampling
    task automatic settle;
        #2;
    endtask

    initial begin
        rst = 1'b1; rst_w = 1'b1;
        c_a = 16'h0010; c_wd = 16'hBEEF; c_wen = 1'b1;
        d_req = 1'b0; d_a = 16'h0000; d_wd = 16'h0000; d_wen = 1'b0;
        Mrd = 16'h0000;

        // reset cycles: CPU write must not reach memory
        tick; settle;
        chk1("rst_mwen_c1", Mwen, 1'b0);
        tick; settle;
        chk1("rst_mwen_c2", Mwen, 1'b0);
        chk1("rst_gnt", d_gnt, 1'b0);

        // idle CPU traffic
        tick; rst = 1'b0; settle;
        chk1("idle_gnt", d_gnt, 1'b0);
        chk1("idle_stall", c_stall, 1'b0);
        chk("idle_xfer", xfer_count, 16'h0000);
        chk("idle_ma", Ma, 16'h0010);
        chk("idle_mwd", Mwd, 16'hBEEF);
        chk1("idle_mwen", Mwen, 1'b1);

        // single DMA read: request rises, grant one cycle later
        tick; c_wen = 1'b0; d_req = 1'b1; d_a = 16'h1234; d_wen = 1'b0; Mrd = 16'h5A5A; settle;
        chk1("rd_req_cycle_gnt", d_gnt, 1'b0);
        tick; settle;
        chk1("rd_gnt", d_gnt, 1'b1);
        chk1("rd_stall", c_stall, 1'b1);
        chk("rd_ma", Ma, 16'h1234);
        chk("rd_d_rd", d_rd, 16'h5A5A);
        chk("rd_c_rd", c_rd, 16'h5A5A);
        chk1("rd_mwen", Mwen, 1'b0);
        chk("rd_xfer_before", xfer_count, 16'h0000);

        // dropped request while still granted, with a write pending
        tick; d_req = 1'b0; d_wen = 1'b1; d_wd = 16'hCAFE; settle;
        chk("rd_xfer_after", xfer_count, 16'h0001);
        chk1("drop_gnt", d_gnt, 1'b1);
        chk1("drop_mwen", Mwen, 1'b0);
        tick; settle;
        chk1("drop_next_gnt", d_gnt, 1'b0);
        chk("drop_xfer", xfer_count, 16'h0001);
        chk("drop_ma_cpu", Ma, 16'h0010);

        // burst limit: expected grant pattern 0, then 1111 00 repeating
        tick; d_req = 1'b1; d_wen = 1'b1; d_a = 16'h2000;
        exp_x = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick;
            settle;
            exp_g = (i > 0) && (((i - 1) % 6) < 4);
            chk1($sformatf("burst_gnt_%0d", i), d_gnt, exp_g);
            chk1($sformatf("burst_mwen_%0d", i), Mwen, exp_g);
            chk($sformatf("burst_xfer_%0d", i), xfer_count, exp_x);
            exp_x = exp_x + {15'd0, exp_g};
        end
        // i=19 opened a fourth burst; drop the request in its second cycle
        tick; d_req = 1'b0; settle;
        chk1("burst_drop_gnt", d_gnt, 1'b1);
        chk1("burst_drop_mwen", Mwen, 1'b0);
        chk("burst_total", xfer_count, 16'd14);

        // reset in the second DMA write cycle
        tick; d_req = 1'b1; d_wen = 1'b1; d_a = 16'h3000; settle;
        chk1("mrst_req_gnt", d_gnt, 1'b0);
        tick; settle;
        chk1("mrst_w1_gnt", d_gnt, 1'b1);
        chk1("mrst_w1_mwen", Mwen, 1'b1);
        tick; rst = 1'b1; settle;
        chk1("mrst_w2_gnt", d_gnt, 1'b1);
        chk1("mrst_w2_mwen", Mwen, 1'b0);
        chk("mrst_w2_xfer", xfer_count, 16'd15);
        tick; rst = 1'b0; d_req = 1'b0; settle;
        chk1("mrst_after_gnt", d_gnt, 1'b0);
        chk1("mrst_after_stall", c_stall, 1'b0);
        chk("mrst_after_xfer", xfer_count, 16'h0000);

        // counter wrap: 15 transfers per 16 cycles, transfer 65536 lands in cycle 69905
        tick; rst_w = 1'b0; settle;
        chk("wrap_start_xfer", xfer_w, 16'h0000);
        chk1("wrap_start_gnt", d_gnt_w, 1'b0);
        repeat (69905) tick;
        settle;
        chk("wrap_pre_xfer", xfer_w, 16'hFFFF);
        chk1("wrap_pre_gnt", d_gnt_w, 1'b1);
        tick; settle;
        chk("wrap_xfer", xfer_w, 16'h0000);
        chk1("wrap_gnt", d_gnt_w, 1'b1);
        chk1("wrap_stall", c_stall_w, 1'b1);
        chk("wrap_ma", Ma_w, 16'h0F0F);
        tick; settle;
        chk("wrap_post_xfer", xfer_w, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
